// File: rtl/entry_pkg.sv
// rtl/entry_pkg.sv - shared types, defaults and helpers for the operand entry controller
// Holds the controller state encoding, the default operand length, the
// BCD width helper and the error-cause codes that drive the err pulse.
package entry_pkg;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ADD     = 2'd2,
        SHOW    = 2'd3
    } entry_state_t;

    localparam int MAX_DIGITS_DEF = 3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DIGIT   = 2'd1;
    localparam logic [1:0] ERR_B_FULL  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic int bcd_w(input int n);
        return 4 * n;
    endfunction

endpackage

// File: rtl/bcd_digit_shifter.sv
// rtl/bcd_digit_shifter.sv - MAX_DIGITS-deep BCD shift register with digit counter
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clr_i          clear value and counter
//   load_first_i   replace value with digit_i as the only digit (count = 1)
//   shift_i        shift digit_i in at the least significant digit when not full
//   digit_i        BCD digit to insert
//   value_o        registered operand
//   value_d_o      next-state operand, lets the parent register a display copy
//   full_o         all MAX_DIGITS digits have been entered
module bcd_digit_shifter
    import entry_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_i,
    input  logic                             load_first_i,
    input  logic                             shift_i,
    input  logic [3:0]                       digit_i,
    output logic [bcd_w(MAX_DIGITS)-1:0]     value_o,
    output logic [bcd_w(MAX_DIGITS)-1:0]     value_d_o,
    output logic                             full_o
);

    localparam int W  = bcd_w(MAX_DIGITS);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [W-1:0]  value_q, value_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign full_o    = (cnt_q == CW'(MAX_DIGITS));
    assign value_o   = value_q;
    assign value_d_o = value_d;

    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            value_d = '0;
            cnt_d   = '0;
        end else if (load_first_i) begin
            value_d = W'(digit_i);
            cnt_d   = CW'(1);
        end else if (shift_i && !full_o) begin
            value_d = (value_q << 4) | W'(digit_i);
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/operand_entry_ctrl.sv
// rtl/operand_entry_ctrl.sv - collects two BCD operands, launches the adder, selects the display
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   digit_i              switch nibble, one BCD digit per load
//   load_pulse           debounced digit-load strobe
//   sum_pulse            debounced sum strobe
//   add_done, add_result adder completion and BCD sum
//   op_a, op_b           BCD operands to the adder
//   add_start            one-cycle adder launch
//   disp_value           BCD value for the 7-segment decoders
//   state_o              current state encoding
//   err                  one-cycle error pulse
module operand_entry_ctrl
    import entry_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        digit_i,
    input  logic                              load_pulse,
    input  logic                              sum_pulse,
    input  logic                              add_done,
    input  logic [bcd_w(MAX_DIGITS+1)-1:0]    add_result,
    output logic [bcd_w(MAX_DIGITS)-1:0]      op_a,
    output logic [bcd_w(MAX_DIGITS)-1:0]      op_b,
    output logic                              add_start,
    output logic [bcd_w(MAX_DIGITS+1)-1:0]    disp_value,
    output logic [1:0]                        state_o,
    output logic                              err
);

    localparam int OPW = bcd_w(MAX_DIGITS);
    localparam int RW  = bcd_w(MAX_DIGITS + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    entry_state_t   state_q, state_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           add_start_q, add_start_d;
    logic           err_q;
    logic [1:0]     err_cause_d;
    logic [RW-1:0]  disp_q, disp_d;

    logic           a_first, a_shift, a_full;
    logic           b_clr, b_first, b_shift, b_full;
    logic [OPW-1:0] a_next, b_next;
    logic           digit_ok;

    assign digit_ok = (digit_i <= 4'd9);

    // A is never cleared on its own: a reload from SHOW overwrites it with the first digit.
    bcd_digit_shifter #(.MAX_DIGITS(MAX_DIGITS)) u_op_a (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (1'b0),
        .load_first_i (a_first),
        .shift_i      (a_shift),
        .digit_i      (digit_i),
        .value_o      (op_a),
        .value_d_o    (a_next),
        .full_o       (a_full)
    );

    bcd_digit_shifter #(.MAX_DIGITS(MAX_DIGITS)) u_op_b (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (b_clr),
        .load_first_i (b_first),
        .shift_i      (b_shift),
        .digit_i      (digit_i),
        .value_o      (op_b),
        .value_d_o    (b_next),
        .full_o       (b_full)
    );

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        add_start_d = 1'b0;
        err_cause_d = ERR_NONE;
        disp_d      = disp_q;
        a_first     = 1'b0;
        a_shift     = 1'b0;
        b_clr       = 1'b0;
        b_first     = 1'b0;
        b_shift     = 1'b0;

        case (state_q)
            ENTER_A: begin
                // Sum has priority; a coincident load is dropped.
                if (sum_pulse) begin
                    state_d     = ADD;
                    add_start_d = 1'b1;
                    tcnt_d      = '0;
                end else if (load_pulse) begin
                    if (!digit_ok) begin
                        err_cause_d = ERR_DIGIT;
                    end else if (!a_full) begin
                        a_shift = 1'b1;
                    end else begin
                        b_first = 1'b1;
                        state_d = ENTER_B;
                    end
                end
            end
            ENTER_B: begin
                if (sum_pulse) begin
                    state_d     = ADD;
                    add_start_d = 1'b1;
                    tcnt_d      = '0;
                end else if (load_pulse) begin
                    if (!digit_ok) begin
                        err_cause_d = ERR_DIGIT;
                    end else if (!b_full) begin
                        b_shift = 1'b1;
                    end else begin
                        err_cause_d = ERR_B_FULL;
                    end
                end
            end
            ADD: begin
                // tcnt_q counts cycles since the launch cycle; done is ignored
                // while add_start is still high.
                if (add_start_q) begin
                    tcnt_d = tcnt_q + TW'(1);
                end else if (add_done) begin
                    disp_d  = add_result;
                    state_d = SHOW;
                end else if (tcnt_q == TW'(TIMEOUT)) begin
                    disp_d      = '0;
                    err_cause_d = ERR_TIMEOUT;
                    state_d     = SHOW;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            SHOW: begin
                if (load_pulse) begin
                    if (!digit_ok) begin
                        err_cause_d = ERR_DIGIT;
                    end else begin
                        a_first = 1'b1;
                        b_clr   = 1'b1;
                        state_d = ENTER_A;
                    end
                end
            end
            default: state_d = ENTER_A;
        endcase

        // While entering, the display follows the operand being edited.
        if (state_d == ENTER_A) begin
            disp_d = RW'(a_next);
        end else if (state_d == ENTER_B) begin
            disp_d = RW'(b_next);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENTER_A;
            tcnt_q      <= '0;
            add_start_q <= 1'b0;
            err_q       <= 1'b0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            add_start_q <= add_start_d;
            err_q       <= (err_cause_d != ERR_NONE);
            disp_q      <= disp_d;
        end
    end

    assign add_start  = add_start_q;
    assign err        = err_q;
    assign disp_value = disp_q;
    assign state_o    = state_q;

endmodule

// File: doc/operand_entry_ctrl.md
# operand_entry_ctrl

Sequencing controller for the BCD adder path of the calculator top. It collects debounced digit-load pulses from the 4-bit dip-switch nibble into two BCD operands, then launches the shared adder on a sum pulse. It captures the adder result and selects what the four 7-segment digit drivers show: operand A, then operand B, then the sum. It sits between the button debouncers/synchronizers and the adder plus 7-segment decoders.

## Interface

Parameters:
- MAX_DIGITS, 3: BCD digits per operand.
- TIMEOUT, 255: maximum cycles to wait for `add_done` after `add_start`.

Ports:
- `clk` in 1: system clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `digit_i` in 4: switch nibble, {ag,bg,cg,dg}, ag = MSB.
- `load_pulse` in 1: one-cycle debounced pulse from `button`.
- `sum_pulse` in 1: one-cycle debounced pulse from `suma_btn`.
- `add_done` in 1: adder result valid, level or pulse.
- `add_result` in 4*(MAX_DIGITS+1): BCD sum from the adder.
- `op_a` out 4*MAX_DIGITS: BCD operand A to the adder.
- `op_b` out 4*MAX_DIGITS: BCD operand B to the adder.
- `add_start` out 1: one-cycle adder launch.
- `disp_value` out 4*(MAX_DIGITS+1): BCD value sent to the 7-segment decoders.
- `state_o` out 2: current state encoding.
- `err` out 1: one-cycle error pulse.

## Operation

States and encodings:
- ENTER_A = 0, ENTER_B = 1, ADD = 2, SHOW = 3.
- Reset state is ENTER_A.

Reset values:
- `op_a`, `op_b`, `disp_value` = 0.
- `add_start`, `err` = 0.
- Digit counters `cnt_a`, `cnt_b` = 0.
- Timeout counter = 0.

Valid digit:
- A digit is valid when `digit_i` ≤ 9.
- A `load_pulse` with `digit_i` > 9 changes no state and pulses `err`.

ENTER_A:
- Valid load with `cnt_a` < MAX_DIGITS: `op_a` ← {`op_a` shifted left one digit, `digit_i`}, `cnt_a`++.
- Valid load with `cnt_a` = MAX_DIGITS: go to ENTER_B, `op_b` ← `digit_i`, `cnt_b` = 1.
- `sum_pulse`: go to ADD (operand B = 0 is legal).

ENTER_B:
- Valid load with `cnt_b` < MAX_DIGITS: shift `digit_i` into `op_b`, `cnt_b`++.
- Valid load with `cnt_b` = MAX_DIGITS: ignored, `err` pulses.
- `sum_pulse`: go to ADD.

ADD:
- `add_start` is high for the first ADD cycle only.
- Wait for `add_done`, then latch `add_result` into `disp_value` and go to SHOW.
- If `add_done` has not arrived after TIMEOUT cycles: `disp_value` ← 0, `err` pulses, go to SHOW.
- `load_pulse` and `sum_pulse` are ignored while in ADD.

SHOW:
- `disp_value` holds the result.
- `sum_pulse` is ignored.
- Valid load: clear `op_a`, `op_b` and both counters, load `digit_i` as the first digit of A (`cnt_a` = 1), go to ENTER_A.

Display source:
- ENTER_A: zero-extended `op_a`.
- ENTER_B: zero-extended `op_b`.
- ADD: previous `disp_value` is held.
- SHOW: latched result.

Simultaneous events:
- `sum_pulse` and `load_pulse` in the same cycle: sum wins and the load is dropped.
- In SHOW the load is acted on, because sum is ignored there.

## Timing

- All outputs are registered.
- A pulse sampled at edge n is reflected in outputs after edge n.
- Load to `op_*`/`disp_value` update: 1 cycle.
- `sum_pulse` to `add_start`: 1 cycle. `add_start` width is exactly 1 cycle.
- `add_done` is sampled starting the cycle after `add_start`; `add_done` coincident with `add_start` is ignored.
- `add_done` to `disp_value` = result and `state_o` = SHOW: 1 cycle.
- Timeout fires on the TIMEOUT-th cycle after `add_start` without `add_done`.
- `err` width is exactly 1 cycle.
- `rst` asserted in any state, including mid-ADD: all outputs return to reset values immediately (asynchronous). `add_start` is not re-issued after release.

## Structure

- Package `entry_pkg` holds:
  - the state enum `entry_state_t`,
  - the MAX_DIGITS default,
  - a width helper `bcd_w(n)` = 4*n,
  - the error-cause constants.
- Sub-module `bcd_digit_shifter`: a parameterised MAX_DIGITS BCD shift register with clear, load-first and shift, plus its own digit counter and `full` flag.
  - It is instantiated twice, once for `op_a` and once for `op_b`.
- The controller FSM and the timeout counter stay in `operand_entry_ctrl`.

## Test plan

1. Reset, then loads 5, 3, 5 → `op_a` = 0x535, `disp_value` = 0x0535, `state_o` = 0.
2. After 1, loads 3, 5, 3 → first 3 moves to ENTER_B; `op_b` = 0x353, `disp_value` = 0x0353. A further load of 3 → `err` pulses and `op_b` is unchanged.
3. After 2, `sum_pulse` → `add_start` is high for 1 cycle, one cycle later. Model `add_done` 2 cycles later with `add_result` = 0x0888 → `disp_value` = 0x0888, `state_o` = 3.
4. Load `digit_i` = 0xC in ENTER_A → `err` pulses; `op_a` and `cnt_a` are unchanged.
5. `sum_pulse` and `load_pulse` (digit 7) in the same cycle in ENTER_A → ADD, `op_a` unchanged. No `add_done` for 255 cycles → `err` pulses, `disp_value` = 0, SHOW.
6. In SHOW, load 9 → ENTER_A, `op_a` = 0x009, `op_b` = 0. Assert `rst` mid-ADD → all outputs return to 0 and state to ENTER_A within the same cycle.
